// File: rtl/float_pkg.sv
// Shared definitions for the float normalizer: default field widths,
// special exponent codes and the FSM state encoding.
package float_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [7:0] EXP_MAX    = 8'hFF;
  localparam logic [7:0] EXP_INF_M1 = 8'hFE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } normStateT;

endpackage

// File: rtl/float_norm_step.sv
// One normalization step: given the working sign/exponent/significand, either
// finishes with a packed result and status flags or produces the shifted operand.
module float_norm_step #(
  parameter int EXP_W  = float_pkg::EXP_W,
  parameter int FRAC_W = float_pkg::FRAC_W
) (
  input  logic                    sign,
  input  logic [EXP_W-1:0]        exp,
  input  logic [FRAC_W+1:0]       sig,
  output logic [EXP_W-1:0]        nextExp,
  output logic [FRAC_W+1:0]       nextSig,
  output logic                    done,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    zero,
  output logic                    ovf,
  output logic                    unf
);

  localparam logic [EXP_W-1:0] expMax   = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] expInfM1 = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] expOne   = {{(EXP_W-1){1'b0}}, 1'b1};

  // Branch order matters: specials first, then carry, then the left-shift walk.
  always_comb begin
    nextExp = exp;
    nextSig = sig;
    done    = 1'b0;
    result  = '0;
    zero    = 1'b0;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (exp == expMax) begin
      done   = 1'b1;
      result = {sign, expMax, sig[FRAC_W-1:0]};
    end else if (sig == '0) begin
      done = 1'b1;
      zero = 1'b1;
    end else if (sig[FRAC_W+1]) begin
      if (exp == expInfM1) begin
        done   = 1'b1;
        ovf    = 1'b1;
        result = {sign, expMax, {FRAC_W{1'b0}}};
      end else begin
        nextSig = sig >> 1;
        nextExp = exp + 1'b1;
      end
    end else if (sig[FRAC_W] && exp != '0) begin
      done   = 1'b1;
      result = {sign, exp, sig[FRAC_W-1:0]};
    end else if (exp <= expOne) begin
      done   = 1'b1;
      unf    = 1'b1;
      result = {sign, {(EXP_W+FRAC_W){1'b0}}};
    end else begin
      nextSig = sig << 1;
      nextExp = exp - 1'b1;
    end
  end

endmodule

// File: rtl/float_normalizer.sv
// Iterative post-add normalizer: accepts a raw sum, shifts one position per
// clock until normalized or a special case is hit, then holds the result.
module float_normalizer #(
  parameter int EXP_W  = float_pkg::EXP_W,
  parameter int FRAC_W = float_pkg::FRAC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [FRAC_W+1:0]      in_sig,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRAC_W:0]  out_float,
  output logic                   out_zero,
  output logic                   out_ovf,
  output logic                   out_unf
);

  import float_pkg::*;

  normStateT state, nextState;

  logic                  signReg;
  logic [EXP_W-1:0]      expReg;
  logic [FRAC_W+1:0]     sigReg;

  logic [EXP_W-1:0]      stepExp;
  logic [FRAC_W+1:0]     stepSig;
  logic                  stepDone;
  logic [EXP_W+FRAC_W:0] stepResult;
  logic                  stepZero, stepOvf, stepUnf;

  float_norm_step #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) stepUnit (
    .sign    (signReg),
    .exp     (expReg),
    .sig     (sigReg),
    .nextExp (stepExp),
    .nextSig (stepSig),
    .done    (stepDone),
    .result  (stepResult),
    .zero    (stepZero),
    .ovf     (stepOvf),
    .unf     (stepUnf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid)  nextState = SHIFT;
      SHIFT:   if (stepDone)  nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs change only on the edge that enters DONE, so they stay put while held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signReg   <= 1'b0;
      expReg    <= '0;
      sigReg    <= '0;
      out_float <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      signReg <= in_sign;
      expReg  <= in_exp;
      sigReg  <= in_sig;
    end else if (state == SHIFT) begin
      if (stepDone) begin
        out_float <= stepResult;
        out_zero  <= stepZero;
        out_ovf   <= stepOvf;
        out_unf   <= stepUnf;
      end else begin
        expReg <= stepExp;
        sigReg <= stepSig;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_float_normalizer.sv
// Directed bench for float_normalizer: expected results are queued on accept
// and compared (value, flags, latency, hold behaviour) when out_valid appears.
module tb_float_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_sig;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic        out_zero, out_ovf, out_unf;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] flt;
    logic        zero;
    logic        ovf;
    logic        unf;
    int          lat;
  } expT;

  expT sb[$];

  float_normalizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, req);
    end
  endtask

  // Drive one raw sum for a single cycle and queue what should come back.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [24:0] g,
                               input logic [31:0] f, input logic z, input logic o,
                               input logic u, input int lat);
    expT item;
    @(negedge clk);
    checkBit("inReadyBeforeAccept", in_ready, 1'b1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_sig   = g;
    item.flt = f; item.zero = z; item.ovf = o; item.unf = u; item.lat = lat;
    sb.push_back(item);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_exp   = 8'($urandom);
    in_sig   = 25'($urandom);
    checkBit("inReadyAfterAccept", in_ready, 1'b0);
  endtask

  // Wait for the result, compare it, hold it under backpressure, then release it.
  task automatic checkOutput(input string tag, input int holdCycles);
    expT  item;
    logic seen = 1'b0;
    int   lat  = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkBit({tag, "_outValidSeen"}, seen, 1'b1);
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_scoreboard: observed empty queue expected one entry", tag);
      return;
    end
    item = sb.pop_front();
    checkEq({tag, "_latency"}, 32'(lat), 32'(item.lat));
    checkEq({tag, "_float"}, out_float, item.flt);
    checkBit({tag, "_zero"}, out_zero, item.zero);
    checkBit({tag, "_ovf"}, out_ovf, item.ovf);
    checkBit({tag, "_unf"}, out_unf, item.unf);
    for (int h = 0; h < holdCycles; h++) begin
      in_valid = 1'b1;
      in_sign  = 1'($urandom);
      in_exp   = 8'($urandom);
      in_sig   = 25'($urandom);
      @(posedge clk);
      #1;
      checkEq({tag, "_holdFloat"}, out_float, item.flt);
      checkBit({tag, "_holdValid"}, out_valid, 1'b1);
      checkBit({tag, "_holdInReady"}, in_ready, 1'b0);
      checkBit({tag, "_holdFlags"}, out_zero | out_ovf | out_unf, item.zero | item.ovf | item.unf);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkBit({tag, "_releasedValid"}, out_valid, 1'b0);
    checkBit({tag, "_releasedInReady"}, in_ready, 1'b1);
    checkEq({tag, "_releasedFloat"}, out_float, item.flt);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic sawValid;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h00;
    in_sig    = 25'h0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkBit("resetOutValid", out_valid, 1'b0);
    checkEq("resetOutFloat", out_float, 32'h0);
    checkBit("resetFlags", out_zero | out_ovf | out_unf, 1'b0);
    reset = 1'b0;
    #1;
    checkBit("resetInReady", in_ready, 1'b1);

    // Already normalized: 3.0
    applyStimulus(1'b0, 8'h80, 25'h0C00000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("normalized", 0);

    // Carry out: one right shift gives 3.0
    applyStimulus(1'b0, 8'h7F, 25'h1800000, 32'h40400000, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("carry", 0);

    // Deep cancellation: 23 left shifts, exponent 0x85-23 = 0x6E
    applyStimulus(1'b0, 8'h85, 25'h0000001, 32'h37000000, 1'b0, 1'b0, 1'b0, 24);
    checkOutput("cancel", 0);

    // Carry at the top exponent overflows to infinity
    applyStimulus(1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("overflow", 0);

    // Left walk reaches exponent 1 before the hidden bit: underflow keeps sign
    applyStimulus(1'b1, 8'h02, 25'h0000010, 32'h80000000, 1'b0, 1'b0, 1'b1, 2);
    checkOutput("underflow", 0);

    // Zero significand forces +0 regardless of sign
    applyStimulus(1'b1, 8'h10, 25'h0000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("zero", 0);

    // Exponent all-ones passes the fraction straight through
    applyStimulus(1'b1, 8'hFF, 25'h0123456, 32'hFF923456, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("special", 0);

    // Hidden bit set but exponent zero is treated as underflow
    applyStimulus(1'b0, 8'h00, 25'h0800000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("expZero", 0);

    // Backpressure with junk on the input side the whole time
    applyStimulus(1'b1, 8'h81, 25'h0A00000, 32'hC0A00000, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("backpressure", 5);

    // Reset in the middle of a long shift walk discards the operation
    applyStimulus(1'b0, 8'h85, 25'h0000001, 32'h37000000, 1'b0, 1'b0, 1'b0, 24);
    sb.delete();
    sawValid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      sawValid |= out_valid;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkBit("midResetOutValid", out_valid, 1'b0);
    checkEq("midResetOutFloat", out_float, 32'h0);
    reset = 1'b0;
    #1;
    checkBit("midResetInReady", in_ready, 1'b1);
    repeat (30) begin
      @(posedge clk);
      #1;
      sawValid |= out_valid;
    end
    checkBit("midResetNoOutput", sawValid, 1'b0);

    // Block is usable again after the aborted operation
    applyStimulus(1'b0, 8'h7F, 25'h1800000, 32'h40400000, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("afterReset", 0);
    checkEq("scoreboardEmpty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
